// File: rtl/av_resp_pkg.sv
// Shared types and constants for the AV I/O bridge response collector.
//   state_e          : collector FSM states (idle / waiting for device / holding ack)
//   NDEV             : number of AV devices behind the bridge
//   ERR_DATA_DEFAULT : read data returned on an error termination
//   sat_inc16        : 16-bit saturating increment
package av_resp_pkg;

    localparam int unsigned NDEV = 8;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/av_prio_mux8.sv
// Lowest-index-first select of one device's read data.
//   req_i   : per-device request (qualified acks), any number of bits may be set
//   dat_i   : per-device read data
//   valid_o : at least one bit of req_i is set
//   dat_o   : data of the lowest set index, zero when nothing is set
module av_prio_mux8
    import av_resp_pkg::*;
(
    input  logic [NDEV-1:0] req_i,
    input  logic [31:0]     dat_i [NDEV],
    output logic            valid_o,
    output logic [31:0]     dat_o
);

    always_comb begin
        valid_o = 1'b0;
        dat_o   = '0;
        // Walk from the top down so the lowest set index is the last to write.
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                dat_o   = dat_i[i];
            end
        end
    end

endmodule

// File: rtl/av_resp_collector.sv
// Response collector and bus watchdog for the AV I/O bridge master side.
// Merges the eight device acks/read data into one registered ack/data pair, terminates
// unselected or unanswered requests with an error ack, and keeps a small error log.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cyc_i, stb_i, we_i  : bus cycle, strobe, write enable from the bridge
//   adr_i, cs_i         : request address and one-hot chip selects
//   dev_ack_i, dev_dat_i: per-device ack and read data
//   ack_o, err_o, dat_o : registered termination, error qualifier, read data
//   stall_o             : held in HOLD and for one turnaround cycle after it
//   err_cnt_o, err_adr_o: saturating error count, address of last error
module av_resp_collector
    import av_resp_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 256,
    parameter logic [31:0] ERR_DATA     = ERR_DATA_DEFAULT,
    // Reset value of the error counter; leave at zero in normal use.
    parameter logic [15:0] ERR_CNT_INIT = 16'h0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [31:0]     adr_i,
    input  logic [NDEV-1:0] cs_i,
    input  logic [NDEV-1:0] dev_ack_i,
    input  logic [31:0]     dev_dat_i [NDEV],
    output logic            ack_o,
    output logic            stall_o,
    output logic [31:0]     dat_o,
    output logic            err_o,
    output logic [15:0]     err_cnt_o,
    output logic [31:0]     err_adr_o
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    // Reads and writes are terminated identically; the direction is not needed.
    logic unused_we;
    assign unused_we = we_i;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [NDEV-1:0] cs_q, cs_d;
    logic [31:0]     adr_q, adr_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     dat_q, dat_d;
    logic            stall_q, stall_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [31:0]     err_adr_q, err_adr_d;

    logic            log_err;
    logic [31:0]     log_adr;
    logic            sel_valid;
    logic [31:0]     sel_dat;

    av_prio_mux8 u_prio_mux8 (
        .req_i   (dev_ack_i & cs_q),
        .dat_i   (dev_dat_i),
        .valid_o (sel_valid),
        .dat_o   (sel_dat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        adr_d     = adr_q;
        ack_d     = ack_q;
        err_d     = err_q;
        dat_d     = dat_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        log_err   = 1'b0;
        log_adr   = adr_q;

        case (state_q)
            StIdle: begin
                // stall_q still high means we are in the turnaround cycle after HOLD.
                if (cyc_i && stb_i && !stall_q) begin
                    cs_d  = cs_i;
                    adr_d = adr_i;
                    // cnt counts cycles since acceptance: the accept cycle is 0, so the
                    // first WAIT cycle sees 1 and the error ack lands in cycle TIMEOUT.
                    cnt_d = 16'd1;
                    if (cs_i == '0) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_d   = ERR_DATA;
                        state_d = StHold;
                        log_err = 1'b1;
                        log_adr = adr_i;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!cyc_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (sel_valid) begin
                    // A qualified ack beats a timeout falling in the same cycle.
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    dat_d   = sel_dat;
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    dat_d   = ERR_DATA;
                    state_d = StHold;
                    cnt_d   = '0;
                    log_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHold: begin
                if (!stb_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    dat_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                dat_d   = '0;
            end
        endcase

        if (log_err) begin
            err_cnt_d = sat_inc16(err_cnt_q);
            err_adr_d = log_adr;
        end

        // High for every HOLD cycle plus the first cycle after leaving it.
        stall_d = (state_d == StHold) || (state_q == StHold);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cs_q      <= '0;
            adr_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            stall_q   <= 1'b0;
            err_cnt_q <= ERR_CNT_INIT;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
            adr_q     <= adr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            stall_q   <= stall_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign dat_o     = dat_q;
    assign stall_o   = stall_q;
    assign err_cnt_o = err_cnt_q;
    assign err_adr_o = err_adr_q;

endmodule
